// File: rtl/i2c_reg_sequencer_if.sv
// i2c_reg_sequencer_if: host command, read-stream and i2c_master byte-handshake bundle.
// The master modport is the sequencer's view; the slave modport is the host plus i2c_master.
interface i2c_reg_sequencer_if #(
    parameter int MAX_LEN = 4
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [6:0]           cmd_dev;
    logic [7:0]           cmd_reg;
    logic                 cmd_rd;
    logic [2:0]           cmd_len;
    logic [8*MAX_LEN-1:0] cmd_wdata;
    logic                 rd_valid;
    logic [7:0]           rd_data;
    logic                 rd_last;
    logic                 done;
    logic [1:0]           err;
    logic                 i2c_enable;
    logic [6:0]           i2c_addr;
    logic                 i2c_rw;
    logic [7:0]           i2c_data_wr;
    logic                 i2c_busy;
    logic                 i2c_ack_error;
    logic [7:0]           i2c_data_rd;

    modport master (
        input  cmd_valid, cmd_dev, cmd_reg, cmd_rd, cmd_len, cmd_wdata,
        input  i2c_busy, i2c_ack_error, i2c_data_rd,
        output cmd_ready, rd_valid, rd_data, rd_last, done, err,
        output i2c_enable, i2c_addr, i2c_rw, i2c_data_wr
    );

    modport slave (
        output cmd_valid, cmd_dev, cmd_reg, cmd_rd, cmd_len, cmd_wdata,
        output i2c_busy, i2c_ack_error, i2c_data_rd,
        input  cmd_ready, rd_valid, rd_data, rd_last, done, err,
        input  i2c_enable, i2c_addr, i2c_rw, i2c_data_wr
    );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns one register-access command into a byte-by-byte i2c_master
// transaction using the busy rise (byte latched) / busy fall (byte finished) handshake.
module i2c_reg_sequencer #(
    parameter int MAX_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input logic                 clk,
    input logic                 rst_n,
    i2c_reg_sequencer_if.master bus
);
    localparam int IW = $clog2(MAX_LEN + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DRAIN} state_e;

    state_e               state_q, state_d;
    logic                 busy_prev_q;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        len_q, len_d;
    logic                 rd_q, rd_d;
    logic [8*MAX_LEN-1:0] wdata_q, wdata_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 rd_last_q, rd_last_d;
    logic                 done_q, done_d;
    logic [1:0]           err_q, err_d;
    logic                 en_q, en_d;
    logic [6:0]           addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic [7:0]           dwr_q, dwr_d;
    logic                 rise, fall, timeout, nack;
    logic [IW-1:0]        len_c;

    assign rise    = bus.i2c_busy & ~busy_prev_q;
    assign fall    = ~bus.i2c_busy & busy_prev_q;
    assign timeout = (state_q != IDLE) && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign nack    = fall && bus.i2c_ack_error;
    assign len_c   = (bus.cmd_len == 3'd0)            ? IW'(1)       :
                     (int'(bus.cmd_len) > MAX_LEN)    ? IW'(MAX_LEN) : IW'(bus.cmd_len);

    // Byte j of the transaction (1 = dev+reg) is in flight while idx_q == j, so the
    // fall for byte j arrives with idx_q == j; read bytes are j >= 2.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        cnt_d      = (state_q == IDLE || rise || fall) ? '0 : cnt_q + 1'b1;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_last_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        en_d       = en_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        dwr_d      = dwr_q;
        if (state_q == IDLE) begin
            if (bus.cmd_valid && cmd_ready_q) begin
                len_d   = len_c;
                rd_d    = bus.cmd_rd;
                wdata_d = bus.cmd_wdata;
                idx_d   = '0;
                err_d   = 2'b00;
                en_d    = 1'b1;
                addr_d  = bus.cmd_dev;
                rw_d    = 1'b0;
                dwr_d   = bus.cmd_reg;
                state_d = ISSUE;
            end
        end else if (timeout) begin
            en_d    = 1'b0;
            err_d   = 2'b10;
            done_d  = 1'b1;
            state_d = IDLE;
        end else if (nack) begin
            en_d    = 1'b0;
            err_d   = 2'b01;
            state_d = DRAIN;
        end else begin
            if (fall && rw_q && idx_q >= IW'(2)) begin
                rd_valid_d = 1'b1;
                rd_data_d  = bus.i2c_data_rd;
                rd_last_d  = (idx_q == len_q + 1'b1);
            end
            if (state_q == ISSUE) begin
                if (rise) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_d == len_q + 1'b1) begin
                        en_d    = 1'b0;
                        state_d = WAIT_DONE;
                    end else if (rd_q) begin
                        rw_d = 1'b1;
                    end else begin
                        dwr_d = wdata_q[8*idx_q +: 8];
                    end
                end
            end else if (!bus.i2c_busy) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
        cmd_ready_d = (state_d == IDLE) && !done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_prev_q <= 1'b0;
            idx_q       <= '0;
            len_q       <= '0;
            rd_q        <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 2'b00;
            en_q        <= 1'b0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            dwr_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_prev_q <= bus.i2c_busy;
            idx_q       <= idx_d;
            len_q       <= len_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            dwr_q       <= dwr_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_last     = rd_last_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.i2c_enable  = en_q;
    assign bus.i2c_addr    = addr_q;
    assign bus.i2c_rw      = rw_q;
    assign bus.i2c_data_wr = dwr_q;
endmodule
